// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of imem_loader.
// The slave modport is the loader; the master modport is the byte source and monitor side.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  words_loaded;

    modport slave (
        input  in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata, start, busy, done, err, words_loaded
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata, start, busy, done, err, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Length-prefixed big-endian byte-stream loader for the instruction memory; pulses start when done.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [7:0] BASE_ADDR = 8'd100,
    parameter logic [7:0] ADDR_STEP = 8'd4
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StData, StWrite, StEnd, StStart} state_e;

    state_e      state_q, state_d;
    logic [7:0]  n_q;
    logic [1:0]  cnt_q;
    logic [31:0] word_q;
    logic [7:0]  addr_q;
    logic [7:0]  wl_q;
    logic        done_q;
    logic        err_q;
    logic [7:0]  addr_out_q;
    logic [31:0] wdata_out_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic ready;
    logic xfer;
    logic we;
    logic start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        we      = 1'b0;
        start   = 1'b0;
        case (state_q)
            StIdle:  ready = 1'b1;
            StData:  ready = 1'b1;
            StWrite: we    = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            StEnd:   ready = 1'b1;
`else
            StEnd:   start = 1'b1;
`endif
            StStart: start = 1'b1;
            default: ;
        endcase
        // Nothing is accepted while reset is held.
        ready = ready & rst_n;
        xfer  = ready & bus.in_valid;

        case (state_q)
            StIdle: begin
                if (xfer) state_d = (bus.in_data == 8'd0) ? StEnd : StData;
            end
            StData: begin
                if (xfer && cnt_q == 2'd3) state_d = StWrite;
            end
            StWrite: begin
                state_d = ((wl_q + 8'd1) == n_q) ? StEnd : StData;
            end
            StEnd: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (xfer) state_d = (bus.in_data == csum_q) ? StStart : StIdle;
`else
                state_d = StIdle;
`endif
            end
            StStart: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q         <= 8'd0;
            cnt_q       <= 2'd0;
            word_q      <= 32'd0;
            addr_q      <= 8'd0;
            wl_q        <= 8'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            addr_out_q  <= 8'd0;
            wdata_out_q <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (xfer) begin
                        n_q    <= bus.in_data;
                        cnt_q  <= 2'd0;
                        addr_q <= BASE_ADDR;
                        wl_q   <= 8'd0;
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q <= 8'd0;
`endif
                    end
                end
                StData: begin
                    if (xfer) begin
                        word_q <= {word_q[23:0], bus.in_data};
                        cnt_q  <= cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ bus.in_data;
`endif
                        // Output registers only move on a write so they hold between strobes.
                        if (cnt_q == 2'd3) begin
                            addr_out_q  <= addr_q;
                            wdata_out_q <= {word_q[23:0], bus.in_data};
                        end
                    end
                end
                StWrite: begin
                    wl_q   <= wl_q + 8'd1;
                    addr_q <= addr_q + ADDR_STEP;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                StEnd: begin
                    if (xfer && bus.in_data != csum_q) err_q <= 1'b1;
                end
`endif
                default: ;
            endcase
            if (start) done_q <= 1'b1;
        end
    end

    assign bus.in_ready     = ready;
    assign bus.im_we        = we;
    assign bus.im_addr      = addr_out_q;
    assign bus.im_wdata     = wdata_out_q;
    assign bus.start        = start;
    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.words_loaded = wl_q;

endmodule
